// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI slave register file.
// Frame: rw bit, address field, then one or more data words.
package spi_slave_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_DONE
  } state_e;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  // Sampling edges needed for a frame of nw data words.
  function automatic int frame_bits(
    input int aw,
    input int dw,
    input int nw
  );
    return 1 + aw + nw * dw;
  endfunction

endpackage

// File: rtl/spi_slave_regs.sv
// DEPTH x DATA_W register array.
// Synchronous write, asynchronous read, async clear.
module spi_slave_regs #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2048
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic w_ok;
  logic r_ok;

  assign w_ok = 32'(waddr) < 32'(DEPTH);
  assign r_ok = 32'(raddr) < 32'(DEPTH);

  // Out-of-range addresses never touch the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we && w_ok) begin
      mem_q[waddr[IDX_W-1:0]] <= wdata;
    end
  end

  // Unimplemented addresses read as zero.
  always_comb begin
    rdata = '0;
    if (r_ok) begin
      rdata = mem_q[raddr[IDX_W-1:0]];
    end
  end

endmodule

// File: rtl/spi_slave_regfile.sv
// SPI slave front end: frame FSM, counters, shifters.
// Burst frames auto-increment and wrap at DEPTH-1.
module spi_slave_regfile
  import spi_slave_pkg::*;
#(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 2048,
  parameter bit BURST_EN = 1'b1
) (
  input  logic              SCLK,
  input  logic              reset,
  input  logic              CS,
  input  logic              SDI,
  output logic              SDO,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              frame_done,
  output logic              frame_abort,
  output logic              addr_err
);

  localparam int MAX_W =
    (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = $clog2(MAX_W + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic              word_q, word_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [DATA_W-1:0] sdo_q, sdo_d;
  logic              wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              done_q, done_d;
  logic              abort_q, abort_d;
  logic              err_q, err_d;

  logic              we;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] addr_full;
  logic [ADDR_W-1:0] addr_inc;
  logic [DATA_W-1:0] word_full;
  logic              cur_ok;
  logic              full_ok;
  logic              inc_ok;
  logic              is_rd;

  assign addr_full = {addr_q[ADDR_W-2:0], SDI};
  assign word_full = {sh_q[DATA_W-2:0], SDI};
  assign addr_inc  =
    (32'(addr_q) == 32'(DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);
  assign cur_ok    = 32'(addr_q) < 32'(DEPTH);
  assign full_ok   = 32'(addr_full) < 32'(DEPTH);
  assign inc_ok    = 32'(addr_inc) < 32'(DEPTH);
  assign is_rd     = (rw_q == RW_READ);

  spi_slave_regs #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_regs (
    .clk   (SCLK),
    .rst_n (reset),
    .we    (we),
    .waddr (addr_q),
    .wdata (word_full),
    .raddr (raddr),
    .rdata (rdata)
  );

  // Next-state, shifter and status-pulse logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    rw_d        = rw_q;
    word_d      = word_q;
    sh_d        = sh_q;
    sdo_d       = sdo_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_strobe_d = 1'b0;
    done_d      = 1'b0;
    abort_d     = 1'b0;
    err_d       = 1'b0;
    we          = 1'b0;
    raddr       = addr_inc;
    if (CS) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      sdo_d   = '0;
      unique case (state_q)
        ST_CMD, ST_ADDR: abort_d = 1'b1;
        ST_DATA: begin
          if (cnt_q == '0 && word_q) begin
            done_d = 1'b1;
          end else begin
            abort_d = 1'b1;
          end
        end
        ST_DONE: done_d = 1'b1;
        default: ;
      endcase
    end else begin
      unique case (state_q)
        ST_IDLE, ST_CMD: begin
          rw_d    = SDI;
          state_d = ST_ADDR;
          cnt_d   = '0;
          word_d  = 1'b0;
          addr_d  = '0;
        end
        ST_ADDR: begin
          addr_d = addr_full;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ADDR_W - 1)) begin
            state_d = ST_DATA;
            cnt_d   = '0;
            raddr   = addr_full;
            sdo_d   = (is_rd && full_ok) ? rdata : '0;
          end
        end
        ST_DATA: begin
          sh_d  = word_full;
          sdo_d = {sdo_q[DATA_W-2:0], 1'b0};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            cnt_d  = '0;
            word_d = 1'b1;
            err_d  = ~cur_ok;
            if (!is_rd && cur_ok) begin
              we          = 1'b1;
              wr_strobe_d = 1'b1;
              wr_addr_d   = addr_q;
              wr_data_d   = word_full;
            end
            if (BURST_EN) begin
              addr_d = addr_inc;
              sdo_d  = (is_rd && inc_ok) ? rdata : '0;
            end else begin
              state_d = ST_DONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge SCLK or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      rw_q        <= RW_READ;
      word_q      <= 1'b0;
      sh_q        <= '0;
      sdo_q       <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      rw_q        <= rw_d;
      word_q      <= word_d;
      sh_q        <= sh_d;
      sdo_q       <= sdo_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
      err_q       <= err_d;
    end
  end

  assign SDO = ~CS & (state_q == ST_DATA)
             & is_rd & sdo_q[DATA_W-1];

  assign wr_strobe   = wr_strobe_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign frame_done  = done_q;
  assign frame_abort = abort_q;
  assign addr_err    = err_q;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Directed bench for spi_slave_regfile.
// Instance a: DEPTH=2048, instance b: DEPTH=16.
module tb_spi_slave_regfile;
  import spi_slave_pkg::*;

  logic SCLK = 1'b0;
  logic reset;
  logic cs;
  logic SDI;
  logic sel;
  logic cs_a;
  logic cs_b;

  assign cs_a = cs | sel;
  assign cs_b = cs | ~sel;

  logic        sdo_a, st_a_o, dn_a_o, ab_a_o, er_a_o;
  logic [10:0] wa_a;
  logic [7:0]  wd_a;
  logic        sdo_b, st_b_o, dn_b_o, ab_b_o, er_b_o;
  logic [10:0] wa_b;
  logic [7:0]  wd_b;

  spi_slave_regfile dut_a (
    .SCLK        (SCLK),
    .reset       (reset),
    .CS          (cs_a),
    .SDI         (SDI),
    .SDO         (sdo_a),
    .wr_strobe   (st_a_o),
    .wr_addr     (wa_a),
    .wr_data     (wd_a),
    .frame_done  (dn_a_o),
    .frame_abort (ab_a_o),
    .addr_err    (er_a_o)
  );

  spi_slave_regfile #(.DEPTH(16)) dut_b (
    .SCLK        (SCLK),
    .reset       (reset),
    .CS          (cs_b),
    .SDI         (SDI),
    .SDO         (sdo_b),
    .wr_strobe   (st_b_o),
    .wr_addr     (wa_b),
    .wr_data     (wd_b),
    .frame_done  (dn_b_o),
    .frame_abort (ab_b_o),
    .addr_err    (er_b_o)
  );

  always #5 SCLK = ~SCLK;

  int n_chk = 0;
  int n_fail = 0;
  int st_a = 0, dn_a = 0, ab_a = 0, er_a = 0;
  int st_b = 0, dn_b = 0, ab_b = 0, er_b = 0;
  int s_st, s_dn, s_ab, s_er;
  int t_st, t_dn, t_ab, t_er;

  always @(negedge SCLK) begin
    if (st_a_o) st_a++;
    if (dn_a_o) dn_a++;
    if (ab_a_o) ab_a++;
    if (er_a_o) er_a++;
    if (st_b_o) st_b++;
    if (dn_b_o) dn_b++;
    if (ab_b_o) ab_b++;
    if (er_b_o) er_b++;
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    s_st = st_a; s_dn = dn_a; s_ab = ab_a; s_er = er_a;
    t_st = st_b; t_dn = dn_b; t_ab = ab_b; t_er = er_b;
  endtask

  task automatic xfer(
    input  logic        s,
    input  logic        rw,
    input  logic [10:0] addr,
    input  logic [7:0]  d0,
    input  logic [7:0]  d1,
    input  int          nbits,
    input  bit          rel,
    output logic [15:0] rd
  );
    logic [27:0] str;
    str = {rw, addr, d0, d1};
    rd  = '0;
    sel = s;
    for (int i = 0; i < nbits; i++) begin
      @(negedge SCLK);
      if (i >= 12 && i < 28) rd[27-i] = s ? sdo_b : sdo_a;
      cs  = 1'b0;
      SDI = str[27-i];
    end
    if (rel) begin
      @(negedge SCLK);
      cs  = 1'b1;
      SDI = 1'b0;
      repeat (3) @(negedge SCLK);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] rd;
    int f1, f2;
    f1 = frame_bits(11, 8, 1);
    f2 = frame_bits(11, 8, 2);
    reset = 1'b0;
    cs    = 1'b1;
    SDI   = 1'b0;
    sel   = 1'b0;
    #1;
    chk("rst_sdo", 32'(sdo_a), 0);
    chk("rst_outs", {st_a_o, dn_a_o, ab_a_o, er_a_o}, 0);
    chk("rst_wr_addr", 32'(wa_a), 0);
    chk("rst_wr_data", 32'(wd_a), 0);
    repeat (2) @(negedge SCLK);
    reset = 1'b1;
    repeat (2) @(negedge SCLK);

    snap();
    xfer(0, RW_WRITE, 11'h639, 8'hB3, 8'h00, f1, 1, rd);
    chk("w1_strobes", st_a - s_st, 1);
    chk("w1_done", dn_a - s_dn, 1);
    chk("w1_abort", ab_a - s_ab, 0);
    chk("w1_wr_addr", 32'(wa_a), 32'h639);
    chk("w1_wr_data", 32'(wd_a), 32'hB3);

    snap();
    xfer(0, RW_READ, 11'h639, 8'h00, 8'h00, f1, 1, rd);
    chk("r1_data", 32'(rd[15:8]), 32'hB3);
    chk("r1_done", dn_a - s_dn, 1);
    chk("r1_strobes", st_a - s_st, 0);

    snap();
    xfer(0, RW_WRITE, 11'h7FF, 8'h11, 8'h22, f2, 1, rd);
    chk("bw_strobes", st_a - s_st, 2);
    chk("bw_done", dn_a - s_dn, 1);
    chk("bw_wr_addr", 32'(wa_a), 32'h000);
    chk("bw_wr_data", 32'(wd_a), 32'h22);

    xfer(0, RW_READ, 11'h7FF, 8'h00, 8'h00, f2, 1, rd);
    chk("br_wrap", 32'(rd), 32'h1122);

    snap();
    xfer(0, RW_WRITE, 11'h639, 8'h55, 8'h00, 8, 1, rd);
    chk("ab_addr_abort", ab_a - s_ab, 1);
    chk("ab_addr_done", dn_a - s_dn, 0);
    chk("ab_addr_strobe", st_a - s_st, 0);

    snap();
    xfer(0, RW_WRITE, 11'h639, 8'h55, 8'h00, 16, 1, rd);
    chk("ab_data_abort", ab_a - s_ab, 1);
    chk("ab_data_strobe", st_a - s_st, 0);
    snap();
    xfer(0, RW_READ, 11'h639, 8'h00, 8'h00, f1, 1, rd);
    chk("ab_readback", 32'(rd[15:8]), 32'hB3);
    chk("ab_next_done", dn_a - s_dn, 1);

    snap();
    xfer(1, RW_WRITE, 11'h020, 8'h5A, 8'h00, f1, 1, rd);
    chk("oor_w_err", er_b - t_er, 1);
    chk("oor_w_strobe", st_b - t_st, 0);
    chk("oor_w_done", dn_b - t_dn, 1);
    snap();
    xfer(1, RW_READ, 11'h020, 8'h00, 8'h00, f1, 1, rd);
    chk("oor_r_data", 32'(rd[15:8]), 0);
    chk("oor_r_err", er_b - t_er, 1);
    snap();
    xfer(1, RW_WRITE, 11'h00F, 8'hC4, 8'hE1, f2, 1, rd);
    chk("b_bw_strobes", st_b - t_st, 2);
    chk("b_bw_err", er_b - t_er, 0);
    xfer(1, RW_READ, 11'h00F, 8'h00, 8'h00, f2, 1, rd);
    chk("b_br_wrap", 32'(rd), 32'hC4E1);

    xfer(0, RW_WRITE, 11'h123, 8'h9C, 8'h00, f1, 1, rd);
    chk("pre_rst_wr_addr", 32'(wa_a), 32'h123);
    snap();
    xfer(0, RW_READ, 11'h639, 8'h00, 8'h00, 14, 0, rd);
    @(posedge SCLK);
    #2;
    chk("pre_rst_sdo", 32'(sdo_a), 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_sdo", 32'(sdo_a), 0);
    chk("mid_rst_wr_addr", 32'(wa_a), 0);
    chk("mid_rst_wr_data", 32'(wd_a), 0);
    chk("mid_rst_outs", {st_a_o, dn_a_o, ab_a_o, er_a_o}, 0);
    cs = 1'b1;
    repeat (2) @(negedge SCLK);
    reset = 1'b1;
    repeat (2) @(negedge SCLK);
    chk("mid_rst_no_abort", ab_a - s_ab, 0);
    xfer(0, RW_READ, 11'h639, 8'h00, 8'h00, f1, 1, rd);
    chk("rst_clr_639", 32'(rd[15:8]), 0);
    xfer(0, RW_READ, 11'h123, 8'h00, 8'h00, f1, 1, rd);
    chk("rst_clr_123", 32'(rd[15:8]), 0);
    snap();
    xfer(0, RW_WRITE, 11'h0A5, 8'h3C, 8'h00, f1, 1, rd);
    chk("post_rst_strobe", st_a - s_st, 1);
    xfer(0, RW_READ, 11'h0A5, 8'h00, 8'h00, f1, 1, rd);
    chk("post_rst_read", 32'(rd[15:8]), 32'h3C);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave_regfile.md
# spi_slave_regfile

Parametrised SPI slave with an internal register file, the next generation of the team's fixed-format SPI slave. It decodes serial frames of one read/write control bit, an ADDR_W-bit address and one or more DATA_W-bit data words. It supports auto-incrementing burst transfers, read-back on SDO, out-of-range detection and clean abort on early CS release. It sits at the chip boundary between the external SPI master and the configuration registers.

## Interface
- ADDR_W, 11: address field width in bits.
- DATA_W, 8: data word width in bits.
- DEPTH, 2048: number of implemented registers, 1 ≤ DEPTH ≤ 2^ADDR_W.
- BURST_EN, 1: 1 enables auto-increment multi-word frames; 0 ends the frame after one word.

Ports:
- SCLK  in  1  sole clock, free-running; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- CS  in  1  chip select, active-low, sampled on rising SCLK.
- SDI  in  1  serial data in, MSB-first.
- SDO  out  1  serial read data, MSB-first.
- wr_strobe  out  1  one-cycle pulse when a register is written.
- wr_addr  out  ADDR_W  address of the last write.
- wr_data  out  DATA_W  data of the last write.
- frame_done  out  1  one-cycle pulse when a frame ends cleanly.
- frame_abort  out  1  one-cycle pulse when a frame ends mid-word.
- addr_err  out  1  one-cycle pulse when an access targets addr ≥ DEPTH.

## Operation
- The states are IDLE, CMD, ADDR, DATA, and DONE.
  - DONE is entered only when BURST_EN=0. It holds until CS goes high.
- In IDLE, a rising edge with CS=0 samples bit 0 as the control bit: rw=1 means write, rw=0 means read. The state then becomes ADDR.
- ADDR shifts in ADDR_W bits, MSB-first, then moves to DATA.
- In DATA, a write shifts in DATA_W bits per word.
  - On the edge that samples the last bit, regfile[addr] is updated.
  - wr_addr and wr_data are updated, and wr_strobe pulses in the following cycle.
- In DATA, a read loads regfile[addr] into the output shift register on the edge that samples the last address bit.
  - SDO shows the MSB after that edge and shifts one bit per subsequent edge.
- Burst, when BURST_EN=1 and CS stays low after a full word:
  - addr increments, wrapping from DEPTH-1 to 0.
  - For reads, the next word is loaded on the edge that completes the current one.
- An address ≥ DEPTH blocks writes and makes reads return 0. addr_err pulses once per word so affected.
- CS sampled high ends the frame, and SDI is not sampled on that edge. The state returns to IDLE.
  - If CS rises at a word boundary with ≥1 word complete, frame_done pulses.
  - If CS rises at any other point, frame_abort pulses. A partial word is discarded and no write occurs.
  - This also applies in CMD and ADDR.
- SDO is 0 whenever CS is high or the frame is a write.

## Timing
- Reset (asynchronous, reset=0):
  - state goes to IDLE.
  - SDO, wr_strobe, frame_done, frame_abort, addr_err, wr_addr and wr_data go to 0.
  - All registers are cleared to 0.
- Reset mid-frame aborts the frame without a frame_abort pulse.
- A single-word frame takes 1+ADDR_W+DATA_W sampling edges, which is 20 at the defaults.
- Write latency: the register is updated on the last-bit edge; wr_strobe is high in the cycle after it.
- Read: the master samples read bit k on the (k+1)-th edge after the last address bit.
- The three status pulses are mutually exclusive in a cycle, except that addr_err may coincide with frame_done.

## Structure
- spi_slave_pkg holds:
  - the state enum;
  - the RW_WRITE=1 and RW_READ=0 constants;
  - a helper function for the frame bit count.
- One sub-module, spi_slave_regs: the DEPTH×DATA_W register array, with a synchronous write port, an asynchronous read port and asynchronous reset.
- The top level holds the FSM, bit counter (width clog2(max(ADDR_W,DATA_W)+1)), address counter and shift registers.

## Test plan
- Write addr 0x639, data 0xB3 (CS low for 20 edges, then high): regfile[0x639]=0xB3; wr_strobe pulses once with wr_addr=0x639 and wr_data=0xB3; frame_done pulses.
- Read addr 0x639 after that write: SDO shows 1,0,1,1,0,0,1,1 on the 8 edges after the address; frame_done pulses; regfile is unchanged.
- Burst write at addr 0x7FF with data 0x11 then 0x22, DEPTH=2048: regfile[0x7FF]=0x11 and regfile[0x000]=0x22 (wrap); two wr_strobe pulses.
- CS high after 8 bits (mid-address): frame_abort pulses, no write occurs, and the next full frame decodes correctly.
- With DEPTH=16, write to addr 0x020: addr_err pulses, no register changes, no wr_strobe; a read of the same address returns 0x00.
- reset driven low mid data phase: all outputs are 0 immediately, the regfile is cleared, and the next frame decodes from bit 0.
